serial_receiver: RTL
====================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, meaning number of buffered received frames (power of two, >=2).
REQ-002 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port serial_in  input  1  serial line; idles high.
REQ-005 SHALL provide port data_out  output  7  head-of-FIFO data bits.
REQ-006 SHALL provide port parity_err  output  1  head-of-FIFO parity-mismatch flag.
REQ-007 SHALL provide port data_valid  output  1  FIFO non-empty; data_out/parity_err valid.
REQ-008 SHALL provide port data_ready  input  1  consumer pop; pop occurs when data_valid && data_ready.
REQ-009 SHALL provide port framing_err  output  1  one-cycle pulse: frame discarded, stop cycle low.
REQ-010 SHALL provide port overflow  output  1  one-cycle pulse: good frame dropped, FIFO full.
REQ-011 SHALL provide port busy  output  1  high while FSM is not in IDLE.

Function
REQ-012 Frame format SHALL be: start bit 0, 7 data bits LSB first, 1 even-parity bit, then >=1 high cycle; one bit per clk, no oversampling.
REQ-013 Even parity SHALL mean parity bit = XOR of the 7 data bits; mismatch sets parity_err for that entry.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: serial_in=0 while armed -> DATA next cycle; bit counter cleared to 0.
REQ-016 DATA: shift serial_in into bit[counter], counter increments; after 7th bit (counter=6) -> PARITY.
REQ-017 PARITY: capture serial_in as parity bit -> STOP.
REQ-018 STOP: serial_in=1 -> push {parity_err,data} into FIFO -> IDLE; serial_in=0 -> pulse framing_err, no push -> IDLE.
REQ-019 With start sampled in cycle T, data SHALL be sampled T+1..T+7, parity T+8, stop T+9; data_valid high from cycle T+10 if FIFO was empty.
REQ-020 Back-to-back frames SHALL be accepted: a start bit at T+10 begins the next frame.
REQ-021 A low serial_in in STOP SHALL NOT be taken as a new start bit; receiver disarms until serial_in is seen high.
REQ-022 Push when full and no simultaneous pop SHALL drop the new frame and pulse overflow; FIFO contents unchanged.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when full; occupancy unchanged.
REQ-024 Pop when empty SHALL be ignored; data_out value SHALL be unspecified while data_valid=0.
REQ-025 FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-026 Frames with parity mismatch SHALL still be pushed, flagged via parity_err.

Reset
REQ-027 rst=1 at a clk edge SHALL: FSM->IDLE, counter=0, FIFO emptied, data_valid=0, framing_err=0, overflow=0, busy=0, receiver disarmed.
REQ-028 Reset mid-frame SHALL abort the frame with no push and no error pulse.
REQ-029 After reset, the receiver SHALL arm only after sampling serial_in=1 for one cycle; a low line in the first cycle is not a start.

Structure
REQ-030 Shared package SHALL hold DATA_W=7, FRAME_BITS=8, state encoding, and the even-parity function.
REQ-031 FIFO SHALL be a sub-module rx_fifo (width DATA_W+1, depth FIFO_DEPTH) with push/pop/full/empty; the FSM lives in serial_receiver.

Verification
REQ-032 Data 0x55: line 1,0,1,0,1,0,1,0,1,0,1 (idle,start,LSB-first,parity 0,stop) -> data_valid at T+10, data_out=0x55, parity_err=0.
REQ-033 Data 0x7F with parity 1, then 0x01 with parity 0 back-to-back -> entries 0x7F/err=0 then 0x01/err=1 in order.
REQ-034 Data 0x2A, stop cycle held 0 -> framing_err pulse at T+10, data_valid stays 0, no start detected until line returns high.
REQ-035 data_ready=0, five valid frames 0x01..0x05 (FIFO_DEPTH=4) -> overflow pulse on 5th, pops yield 0x01..0x04.
REQ-036 FIFO full, final stop cycle coincident with a pop -> no overflow, occupancy stays 4, new frame last out.
REQ-037 rst asserted at T+4 of frame 0x33 -> busy=0, data_valid=0, no pulses; next clean frame 0x33 received correctly.

Source files
------------

// File: rtl/serial_receiver_pkg.sv
// ============================================================================
// Module      : serial_receiver_pkg
// Description : Shared constants, FSM state encoding and parity helper for the
//               serial receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_receiver_pkg;

    localparam int DATA_W     = 7;
    localparam int FRAME_BITS = 8;  // data bits plus parity flag per FIFO entry

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_W - 1);

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_fifo.sv
// ============================================================================
// Module      : rx_fifo
// Description : Synchronous FIFO with first-word-fall-through head; a push is
//               accepted when full only if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign pop_data = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{c_PTR_W{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{c_PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_receiver.sv
// ============================================================================
// Module      : serial_receiver
// Description : One-bit-per-clock serial frame receiver (start, 7 data LSB
//               first, even parity, stop) feeding a small frame FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              framing_err,
    output logic              overflow,
    output logic              busy
);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [2:0]            r_bit_cnt;
    logic [DATA_W-1:0]     r_data;
    logic                  r_parity;
    logic                  r_armed;
    logic                  r_framing_err;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_frame_bad;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FRAME_BITS-1:0] w_entry;
    logic [FRAME_BITS-1:0] w_fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (r_armed && !serial_in) w_next_state = c_ST_DATA;
            c_ST_DATA:   if (r_bit_cnt == c_LAST_BIT) w_next_state = c_ST_PARITY;
            c_ST_PARITY: w_next_state = c_ST_STOP;
            c_ST_STOP:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_frame_bad = 1'b0;
        busy        = (r_state != c_ST_IDLE);
        if (r_state == c_ST_STOP) begin
            w_push      = serial_in;
            w_frame_bad = !serial_in;
        end
    end

    // A low stop bit leaves the receiver disarmed so it cannot double as a start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_data        <= '0;
            r_parity      <= 1'b0;
            r_armed       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_framing_err <= w_frame_bad;
            r_overflow    <= w_push && w_fifo_full && !w_pop;
            case (r_state)
                c_ST_IDLE: begin
                    r_bit_cnt <= '0;
                    if (serial_in) begin
                        r_armed <= 1'b1;
                    end
                end
                c_ST_DATA: begin
                    r_data    <= {serial_in, r_data[DATA_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                c_ST_PARITY: r_parity <= serial_in;
                c_ST_STOP:   r_armed  <= serial_in;
                default:     r_bit_cnt <= '0;
            endcase
        end
    end

    assign w_entry = {(r_parity != even_parity(r_data)), r_data};
    assign w_pop   = data_ready && !w_fifo_empty;

    rx_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (data_ready),
        .pop_data  (w_fifo_dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign data_out    = w_fifo_dout[DATA_W-1:0];
    assign parity_err  = w_fifo_dout[DATA_W];
    assign data_valid  = !w_fifo_empty;
    assign framing_err = r_framing_err;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire
